// File: rtl/seg7_scan_decoder_pkg.sv
// Shared constants for the scanned 7-segment display decoder.
// Holds the active-high segment code table (index = hex digit) and FSM state encoding.
// Latency / backpressure: not applicable (package only).
package seg7_scan_decoder_pkg;

    // Active-high segment codes, bit0 = a ... bit6 = g.
    // Packed concatenation lists entry 15 first, so SEG_CODE[i] is the code for digit i.
    localparam logic [15:0][6:0] SEG_CODE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        WAIT_D0 = 1'b0,
        CAP     = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to hex nibble decoder with illegal-pattern flag.
// Latency: zero cycles (pure combinational). Backpressure: none.
// Ports: pattern (active-high segments) in; nibble and illegal out (nibble is 0 when illegal).
module seg7_pattern_decode
    import seg7_scan_decoder_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       illegal
);

    always_comb begin
        nibble  = 4'h0;
        illegal = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_CODE[i]) begin
                nibble  = 4'(i);
                illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers 4-digit hex frames from a multiplexed 7-segment display bus.
// Latency: final digit change to frame_valid/frame_err is 1 + (STABLE_CYCLES-1) + 1 cycles.
// Backpressure: none; the display is observed passively and outputs are single-cycle pulses.
// Ports: clk, rst_n (async active-low); seg_n[6:0], dig_sel_n[3:0] active-low display lines;
//        value[15:0] last good frame, frame_valid/frame_err pulses, err_digit illegal-digit mask.
module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  dig_sel_n,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  err_digit
);

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

    // Sample stage and the previous sample used for change detection.
    logic [6:0]  seg_q, seg_p;
    logic [3:0]  sel_q, sel_p;
    logic [7:0]  cnt, cnt_nxt;

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [15:0] work, work_nxt;
    logic [3:0]  werr, werr_nxt;
    logic [15:0] value_nxt;
    logic        fv_nxt, fe_nxt;
    logic [3:0]  errd_nxt;

    logic        stable, accept, blank, onehot;
    logic [3:0]  sel_act;
    logic [1:0]  dig;
    logic [3:0]  nib;
    logic        ill;

    seg7_pattern_decode u_dec (
        .pattern (~seg_q),
        .nibble  (nib),
        .illegal (ill)
    );

    assign stable  = (seg_q == seg_p) && (sel_q == sel_p);
    assign cnt_nxt = !stable ? 8'd0 : ((cnt == STAB_MAX) ? cnt : cnt + 8'd1);
    // Counter steps to STABLE_CYCLES-1 exactly once per steady period, then saturates.
    assign accept  = stable && (cnt == STAB_MAX - 8'd2);
    assign sel_act = ~sel_q;
    assign blank   = (sel_act == 4'h0);
    assign onehot  = !blank && ((sel_act & (sel_act - 4'd1)) == 4'h0);

    always_comb begin
        dig = 2'd0;
        case (sel_act)
            4'b0010: dig = 2'd1;
            4'b0100: dig = 2'd2;
            4'b1000: dig = 2'd3;
            default: dig = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        work_nxt  = work;
        werr_nxt  = werr;
        value_nxt = value;
        fv_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        errd_nxt  = err_digit;
        if (accept && !blank) begin
            case (state)
                WAIT_D0: begin
                    if (onehot && dig == 2'd0) begin
                        work_nxt[3:0] = nib;
                        werr_nxt      = {3'b000, ill};
                        state_nxt     = CAP;
                        idx_nxt       = 2'd1;
                    end
                end
                CAP: begin
                    if (!onehot) begin
                        fe_nxt    = 1'b1;
                        errd_nxt  = werr;
                        state_nxt = WAIT_D0;
                    end else if (dig == idx) begin
                        work_nxt[{dig, 2'b00} +: 4] = nib;
                        if (ill) werr_nxt[dig] = 1'b1;
                        if (idx == 2'd3) begin
                            state_nxt = WAIT_D0;
                            errd_nxt  = werr_nxt;
                            if (werr_nxt == 4'h0) begin
                                value_nxt = work_nxt;
                                fv_nxt    = 1'b1;
                            end else begin
                                fe_nxt    = 1'b1;
                            end
                        end else begin
                            idx_nxt = idx + 2'd1;
                        end
                    end else begin
                        // Out-of-order digit: report the abort, and if it is digit 0
                        // treat it as the first digit of a fresh frame.
                        fe_nxt    = 1'b1;
                        errd_nxt  = werr;
                        state_nxt = WAIT_D0;
                        if (dig == 2'd0) begin
                            work_nxt[3:0] = nib;
                            werr_nxt      = {3'b000, ill};
                            state_nxt     = CAP;
                            idx_nxt       = 2'd1;
                        end
                    end
                end
                default: state_nxt = WAIT_D0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= '1;
            seg_p       <= '1;
            sel_q       <= '1;
            sel_p       <= '1;
            cnt         <= 8'd0;
            state       <= WAIT_D0;
            idx         <= 2'd0;
            work        <= 16'h0;
            werr        <= 4'h0;
            value       <= 16'h0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_digit   <= 4'h0;
        end else begin
            seg_q       <= seg_n;
            sel_q       <= dig_sel_n;
            seg_p       <= seg_q;
            sel_p       <= sel_q;
            cnt         <= cnt_nxt;
            state       <= state_nxt;
            idx         <= idx_nxt;
            work        <= work_nxt;
            werr        <= werr_nxt;
            value       <= value_nxt;
            frame_valid <= fv_nxt;
            frame_err   <= fe_nxt;
            err_digit   <= errd_nxt;
        end
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning consecutive unchanged cycles required to accept a digit (legal range 2..255).
REQ-002 Clock  input  1  rising-edge system clock.
REQ-003 Resetn  input  1  reset, asynchronous, active-low.
REQ-004 seg_n  input  7  active-low segment lines, bit0=a … bit6=g, same clock domain.
REQ-005 dig_sel_n  input  4  active-low one-hot digit enable of a scanned 4-digit display, bit0 = digit 0 (least significant).
REQ-006 value  output  16  last completed frame, digit k in bits [4k+3:4k].
REQ-007 frame_valid  output  1  one-cycle pulse when value is updated from an error-free frame.
REQ-008 frame_err  output  1  one-cycle pulse when a frame completes or aborts with any error.
REQ-009 err_digit  output  4  per-digit illegal-pattern mask of the last completed or aborted frame.

Function
REQ-010 seg_n and dig_sel_n SHALL be registered once; all decisions use the registered copies (sample stage).
REQ-011 Active-high pattern p = ~seg_n SHALL decode: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F (hex); any other p is illegal.
REQ-012 Stability counter SHALL clear when the sampled seg_n or dig_sel_n differs from the previous sample; otherwise it increments, saturating at STABLE_CYCLES.
REQ-013 A digit SHALL be accepted exactly once per select period, in the cycle the counter reaches STABLE_CYCLES-1 with exactly one dig_sel_n bit low.
REQ-014 An accepted illegal pattern SHALL store nibble 0 and set the corresponding err_digit bit of the frame in progress.
REQ-015 FSM states: WAIT_D0, CAP (expecting digit index n = 1..3), with a 2-bit next-digit index.
REQ-016 WAIT_D0: acceptance of digit 0 stores nibble 0 and clears the working err mask → CAP, n=1; acceptance of other digits is ignored.
REQ-017 CAP: acceptance of digit n stores nibble n; if n=3 → frame complete, → WAIT_D0; else n increments.
REQ-018 CAP: acceptance of a digit ≠ n SHALL abort the frame: frame_err pulse, value unchanged, → WAIT_D0; an out-of-order digit 0 restarts a new frame in the same cycle after the abort pulse is issued.
REQ-019 All-high dig_sel_n (blanking) SHALL be legal in any state and not affect the FSM.
REQ-020 More than one dig_sel_n bit low, stable for STABLE_CYCLES-1 cycles, SHALL abort in CAP (frame_err pulse) and be ignored in WAIT_D0.
REQ-021 On frame complete with empty err mask: value ← 4 stored nibbles and frame_valid=1 in the next cycle; with non-empty mask: value unchanged, frame_err=1 in the next cycle.
REQ-022 err_digit SHALL update in the same cycle as frame_valid/frame_err and hold until the next such pulse.
REQ-023 Latency: input change to frame_valid = 1 (sample) + STABLE_CYCLES-1 (stability) + 1 (output) cycles for the final digit.
REQ-024 frame_valid and frame_err SHALL never be high together.

Reset
REQ-025 Resetn low SHALL asynchronously force: value=0000, frame_valid=0, frame_err=0, err_digit=0, FSM=WAIT_D0, counter=0, sample registers all-ones.
REQ-026 Reset mid-frame SHALL discard partial data with no pulse; capture resumes at the next digit-0 acceptance after release.

Structure
REQ-027 Shared package SHALL hold the 16-entry active-high segment code table and the FSM state encoding constants.
REQ-028 One sub-module seg7_pattern_decode (combinational: 7-bit pattern → 4-bit nibble + illegal flag) SHALL be instantiated; all sequential logic stays in the top.

Verification
REQ-029 Scan 1,2,3,4 (digits 0..3, each held 6 cycles, blanking between) → value=16'h4321, frame_valid single pulse, err_digit=0.
REQ-030 Digit 2 pattern 7'h00 (p=7F inverted as 00? no: p=7'h7F → 8) vs illegal p=7'h01 on digit 2 → frame_err pulse, err_digit=4'b0100, value unchanged.
REQ-031 Digit 1 pattern held only STABLE_CYCLES-2 cycles → not accepted; digit 2 then arrives → frame_err (abort), value unchanged.
REQ-032 Order 0,2 → frame_err pulse on digit 2 acceptance; subsequent clean 0..3 scan of A,B,C,D → value=16'hDCBA.
REQ-033 Resetn asserted asynchronously after digit 2 accepted → all outputs 0 immediately; next full scan of F,F,F,F → value=16'hFFFF, frame_valid.
REQ-034 dig_sel_n=4'b1100 held stable in CAP → frame_err pulse, FSM returns to WAIT_D0.
